resta_sat_pipe: RTL and testbench

RESTA_SAT_PIPE -- requirements
Module: resta_sat_pipe

---
 rtl/resta_sat_pipe_pkg.sv | 16 +
 rtl/resta_sat_pipe_sat_clamp.sv | 33 +++
 rtl/resta_sat_pipe.sv | 108 ++++++++++
 tb/tb_resta_sat_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resta_sat_pipe_pkg.sv
// Fixed-point constants shared by the Suma/Resta saturating datapaths.
// Symmetric clamp limits are derived from the default operand width.
package resta_sat_pipe_pkg;

    localparam int N_DEF = 25;
    localparam int CNT_W = 16;

    localparam logic [N_DEF-1:0] SAT_POS = {1'b0, {(N_DEF-1){1'b1}}};
    localparam logic [N_DEF-1:0] SAT_NEG = {1'b1, {(N_DEF-2){1'b0}}, 1'b1};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

endpackage

// File: rtl/resta_sat_pipe_sat_clamp.sv
// Combinational saturation of an N+1-bit difference to a symmetric N-bit range.
// The extra raw bit carries the true sign, which picks the clamp direction.
module sat_clamp #(
    parameter int N = 25
) (
    input  logic [N:0]   raw,
    input  logic         sign_a,
    input  logic         sign_b,
    output logic [N-1:0] resta,
    output logic         sat
);

    localparam logic [N-1:0] POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG = {1'b1, {(N-2){1'b0}}, 1'b1};
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    logic ovf;

    always_comb begin
        resta = raw[N-1:0];
        sat   = 1'b0;
        ovf   = (sign_a != sign_b) && (raw[N-1] != sign_a);
        if (ovf) begin
            sat   = 1'b1;
            resta = raw[N] ? NEG : POS;
        end else if (raw[N-1:0] == MIN) begin
            // most-negative code is folded in to keep the range symmetric
            sat   = 1'b1;
            resta = NEG;
        end
    end

endmodule

// File: rtl/resta_sat_pipe.sv
// Two-stage valid/ready saturating subtractor RESTA = sat(A - B).
// Optional saturation event counter enabled by RESTA_SAT_CNT_EN.
module resta_sat_pipe
    import resta_sat_pipe_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             out_valid,
`ifdef RESTA_SAT_CNT_EN
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_cnt,
`endif
    input  logic             out_ready,
    output logic [N-1:0]     RESTA,
    output logic             sat_o
);

    stage_t s1_state, s1_next;
    stage_t s2_state, s2_next;

    logic         s2_xfer;
    logic         s1_adv;
    logic         load1;
    logic [N:0]   diff;
    logic [N:0]   s1_raw;
    logic         s1_sign_a;
    logic         s1_sign_b;
    logic [N-1:0] clamp_resta;
    logic         clamp_sat;

    assign diff = {A[N-1], A} - {B[N-1], B};

    always_comb begin
        s2_xfer   = (s2_state == FULL) && out_ready;
        s1_adv    = (s1_state == FULL) && ((s2_state == EMPTY) || s2_xfer);
        in_ready  = reset_n && ((s1_state == EMPTY) || s1_adv);
        load1     = in_valid && in_ready;
        out_valid = (s2_state == FULL);
        s1_next   = s1_state;
        s2_next   = s2_state;
        if (load1)
            s1_next = FULL;
        else if (s1_adv)
            s1_next = EMPTY;
        if (s1_adv)
            s2_next = FULL;
        else if (s2_xfer)
            s2_next = EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_state <= EMPTY;
            s2_state <= EMPTY;
        end else begin
            s1_state <= s1_next;
            s2_state <= s2_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_raw    <= '0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
        end else if (load1) begin
            s1_raw    <= diff;
            s1_sign_a <= A[N-1];
            s1_sign_b <= B[N-1];
        end
    end

    sat_clamp #(.N(N)) u_clamp (
        .raw    (s1_raw),
        .sign_a (s1_sign_a),
        .sign_b (s1_sign_b),
        .resta  (clamp_resta),
        .sat    (clamp_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RESTA <= '0;
            sat_o <= 1'b0;
        end else if (s1_adv) begin
            RESTA <= clamp_resta;
            sat_o <= clamp_sat;
        end
    end

`ifdef RESTA_SAT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sat_cnt <= '0;
        else if (clr_cnt)
            sat_cnt <= '0;
        else if (s2_xfer && sat_o && (sat_cnt != {CNT_W{1'b1}}))
            sat_cnt <= sat_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_resta_sat_pipe.sv
// Scoreboard bench for resta_sat_pipe: directed boundaries, random stream,
// backpressure, mid-flight reset, and the counter when RESTA_SAT_CNT_EN is set.
module tb_resta_sat_pipe;
    import resta_sat_pipe_pkg::*;

    localparam int N = 25;
    localparam logic [N-1:0] POS_T = 25'h0FFFFFF;
    localparam logic [N-1:0] NEG_T = 25'h1000001;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] RESTA;
    logic         sat_o;
`ifdef RESTA_SAT_CNT_EN
    logic         clr_cnt;
    logic [15:0]  sat_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int out_count = 0;
    int acc_count = 0;
    bit lat_chk = 0;
    bit rnd_or = 0;

    typedef struct {
        logic [N:0] exp;
        int         acc;
    } sb_t;
    sb_t q[$];

    resta_sat_pipe #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
`ifdef RESTA_SAT_CNT_EN
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt),
`endif
        .out_ready (out_ready),
        .RESTA     (RESTA),
        .sat_o     (sat_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a,
                                         input logic [N-1:0] b);
        longint d;
        longint mx;
        d  = longint'($signed(a)) - longint'($signed(b));
        mx = (longint'(1) <<< (N-1)) - 1;
        if (d > mx)
            return {1'b1, POS_T};
        if (d < -mx)
            return {1'b1, NEG_T};
        return {1'b0, d[N-1:0]};
    endfunction

    // scoreboard monitor, sampled on the falling edge
    initial begin
        logic [N-1:0] held;
        bit stall;
        sb_t e;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_resta", 64'(RESTA), 64'(held));
                end
                if (in_valid && in_ready) begin
                    q.push_back('{model(A, B), cyc});
                    acc_count++;
                end
                if (out_valid && out_ready) begin
                    out_count++;
                    if (q.size() == 0) begin
                        chk("out_without_in", 64'(q.size()), 64'(1));
                    end else begin
                        e = q.pop_front();
                        chk("resta", 64'(RESTA), 64'(e.exp[N-1:0]));
                        chk("sat", 64'(sat_o), 64'(e.exp[N]));
                        if (lat_chk)
                            chk("latency", 64'(cyc - e.acc), 64'(2));
                    end
                end
                stall = out_valid && !out_ready;
                held  = RESTA;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_or)
            out_ready = 1'($urandom_range(0, 1));
    end

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        bit ok;
        n = 0;
        A = a;
        B = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        if (!ok)
            chk("push_timeout", 64'(n), 64'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500)
            chk("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    function automatic logic [N-1:0] rnd_op();
        logic [31:0] r;
        logic [N-1:0] v;
        r = $urandom;
        v = N'(r);
        if (r[31:30] == 2'b00)
            v[N-2:0] = r[29] ? '1 : '0;
        return v;
    endfunction

    initial begin
        int a0;
        int o0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        out_ready = 1'b1;
`ifdef RESTA_SAT_CNT_EN
        clr_cnt   = 1'b0;
`endif
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_resta", 64'(RESTA), 64'(0));
        chk("rst_sat", 64'(sat_o), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
`ifdef RESTA_SAT_CNT_EN
        chk("rst_cnt", 64'(sat_cnt), 64'(0));
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'(1));

        lat_chk = 1;
        push(25'h0000005, 25'h0000003);
        push(25'h0FFFFFF, 25'h1FFFFFF);
        drain();
`ifdef RESTA_SAT_CNT_EN
        chk("cnt_one", 64'(sat_cnt), 64'(1));
`endif
        push(25'h1000001, 25'h0000002);
        push(25'h0000000, 25'h1000000);
        push(25'h1FFFFFF, 25'h0FFFFFF);
        push(25'h1000000, 25'h0000000);
        push(25'h1000000, 25'h0000001);
        push(25'h0FFFFFF, 25'h0000000);
        push(25'h1000001, 25'h0000000);
        push(25'h0000003, 25'h0000005);
        drain();

        lat_chk = 0;
        rnd_or  = 1;
        repeat (60) push(rnd_op(), rnd_op());
        rnd_or    = 0;
        out_ready = 1'b1;
        drain();

        // four pairs into a stalled output
        out_ready = 1'b0;
        a0 = acc_count;
        o0 = out_count;
        push(25'h0000010, 25'h0000001);
        push(25'h0FFFFF0, 25'h1FFFF00);
        A = 25'h1000010;
        B = 25'h0000100;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready", 64'(in_ready), 64'(0));
        chk("bp_accepted", 64'(acc_count - a0), 64'(2));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(25'h1000010, 25'h0000100);
        push(25'h0000007, 25'h0000009);
        drain();
        chk("bp_outs", 64'(out_count - o0), 64'(4));

`ifdef RESTA_SAT_CNT_EN
        lat_chk = 1;
        repeat (65537) push(25'h0FFFFFF, 25'h1FFFFFF);
        drain();
        chk("cnt_stick", 64'(sat_cnt), 64'(16'hFFFF));
        clr_cnt = 1'b1;
        push(25'h0FFFFFF, 25'h1FFFFFF);
        drain();
        clr_cnt = 1'b0;
        chk("cnt_clr", 64'(sat_cnt), 64'(0));
`endif

        // reset with both stages full
        lat_chk   = 0;
        out_ready = 1'b0;
        push(25'h0000100, 25'h0000001);
        push(25'h0000200, 25'h0000002);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_resta", 64'(RESTA), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        q.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        o0 = out_count;
        lat_chk = 1;
        push(25'h0000010, 25'h0000020);
        drain();
        repeat (4) @(posedge clk);
        chk("post_rst_outs", 64'(out_count - o0), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
